// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit with HI/LO architectural registers and a busy down-counter.
// Define MDU_MADD_EN to add the MADD/MADDU/MSUB accumulate ops (codes 6-8).
module mult_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    input  logic [3:0]  MDCtrl,
    input  logic        Cancel,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        HILOSel,
    output logic        Busy,
    output logic [31:0] HILO_out
);

    // state   | meaning
    // ST_IDLE | no operation in flight; MTHI/MTLO and new ops accepted
    // ST_MUL  | MULT/MULTU counting down, product written at terminal count
    // ST_DIV  | DIV/DIVU counting down, quotient/remainder written at terminal count
    // ST_MAC  | MADD/MADDU/MSUB counting down, accumulate into {HI,LO} at terminal count

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = (MAXC < 1) ? 1 : $clog2(MAXC + 1);
    localparam logic [CW-1:0] MULT_LD = CW'(MULT_CYCLES);
    localparam logic [CW-1:0] DIV_LD  = CW'(DIV_CYCLES);

    localparam logic [3:0] OP_MULT  = 4'd0;
    localparam logic [3:0] OP_DIV   = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIVU  = 4'd3;
    localparam logic [3:0] OP_MTHI  = 4'd4;
    localparam logic [3:0] OP_MTLO  = 4'd5;
`ifdef MDU_MADD_EN
    localparam logic [3:0] OP_MADD  = 4'd6;
    localparam logic [3:0] OP_MADDU = 4'd7;
    localparam logic [3:0] OP_MSUB  = 4'd8;
`endif
    localparam logic [3:0] OP_NONE  = 4'd15;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_MAC
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    op_q, op_d;
    logic [31:0]   a_q, a_d;
    logic [31:0]   b_q, b_d;
    logic [31:0]   hi_q, hi_d;
    logic [31:0]   lo_q, lo_d;

    logic is_mul, is_div, is_mac, idle, accept;

    always_comb begin
        is_mul = (MDCtrl == OP_MULT) || (MDCtrl == OP_MULTU);
        is_div = (MDCtrl == OP_DIV) || (MDCtrl == OP_DIVU);
`ifdef MDU_MADD_EN
        is_mac = (MDCtrl == OP_MADD) || (MDCtrl == OP_MADDU) || (MDCtrl == OP_MSUB);
`else
        is_mac = 1'b0;
`endif
    end

    // Acceptance uses only the counter so Busy's start term cannot feed back into it.
    assign idle     = (cnt_q == '0);
    assign accept   = Start & ~Cancel & idle;
    assign Busy     = (Start & ~Cancel & (is_mul | is_div | is_mac)) | ~idle;
    assign HILO_out = HILOSel ? lo_q : hi_q;

    logic        op_signed;
    logic [63:0] a64, b64, prod;

    always_comb begin
        op_signed = (op_q == OP_MULT) || (op_q == OP_DIV);
`ifdef MDU_MADD_EN
        op_signed = op_signed || (op_q == OP_MADD) || (op_q == OP_MSUB);
`endif
    end

    // The low 64 bits of a two's-complement product are exact after sign/zero extension.
    assign a64  = {{32{op_signed & a_q[31]}}, a_q};
    assign b64  = {{32{op_signed & b_q[31]}}, b_q};
    assign prod = a64 * b64;

    logic        neg_a, neg_b, div_by_zero;
    logic [31:0] mag_a, mag_b, mag_b_safe, uq, ur, quot, rem;

    // Signed division through magnitudes: truncates toward zero, remainder follows the dividend,
    // and 0x80000000 / -1 naturally wraps back to 0x80000000.
    always_comb begin
        neg_a       = op_signed & a_q[31];
        neg_b       = op_signed & b_q[31];
        mag_a       = neg_a ? (~a_q + 32'd1) : a_q;
        mag_b       = neg_b ? (~b_q + 32'd1) : b_q;
        div_by_zero = (b_q == 32'd0);
        mag_b_safe  = div_by_zero ? 32'd1 : mag_b;
        uq          = mag_a / mag_b_safe;
        ur          = mag_a % mag_b_safe;
        quot        = (neg_a ^ neg_b) ? (~uq + 32'd1) : uq;
        rem         = neg_a ? (~ur + 32'd1) : ur;
    end

`ifdef MDU_MADD_EN
    logic [63:0] mac_res;
    assign mac_res = (op_q == OP_MSUB) ? ({hi_q, lo_q} - prod) : ({hi_q, lo_q} + prod);
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;

        if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (is_mul || is_div || is_mac) begin
                        op_d  = MDCtrl;
                        a_d   = A;
                        b_d   = B;
                        cnt_d = is_div ? DIV_LD : MULT_LD;
                        if (is_div) begin
                            state_d = ST_DIV;
                        end else if (is_mac) begin
                            state_d = ST_MAC;
                        end else begin
                            state_d = ST_MUL;
                        end
                    end else if (MDCtrl == OP_MTHI) begin
                        hi_d = A;
                    end else if (MDCtrl == OP_MTLO) begin
                        lo_d = A;
                    end
                end
            end
            ST_MUL: begin
                if (cnt_q <= CW'(1)) begin
                    {hi_d, lo_d} = prod;
                    state_d      = ST_IDLE;
                    op_d         = OP_NONE;
                end
            end
            ST_DIV: begin
                if (cnt_q <= CW'(1)) begin
                    if (!div_by_zero) begin
                        lo_d = quot;
                        hi_d = rem;
                    end
                    state_d = ST_IDLE;
                    op_d    = OP_NONE;
                end
            end
            ST_MAC: begin
                if (cnt_q <= CW'(1)) begin
`ifdef MDU_MADD_EN
                    {hi_d, lo_d} = mac_res;
`endif
                    state_d = ST_IDLE;
                    op_d    = OP_NONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            op_q    <= OP_NONE;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: busy timing, HI/LO results, ignore rules and async reset.
// Expectations for MADDU follow the MDU_MADD_EN setting of the build.
module tb_mult_div_unit;

    logic        clk;
    logic        reset;
    logic        Start;
    logic [3:0]  MDCtrl;
    logic        Cancel;
    logic [31:0] A;
    logic [31:0] B;
    logic        HILOSel;
    logic        Busy;
    logic [31:0] HILO_out;

    int n_tests = 0;
    int n_fail  = 0;

    mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk      (clk),
        .reset    (reset),
        .Start    (Start),
        .MDCtrl   (MDCtrl),
        .Cancel   (Cancel),
        .A        (A),
        .B        (B),
        .HILOSel  (HILOSel),
        .Busy     (Busy),
        .HILO_out (HILO_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic read_hilo(output logic [31:0] hi, output logic [31:0] lo);
        HILOSel = 1'b0;
        #1 hi = HILO_out;
        HILOSel = 1'b1;
        #1 lo = HILO_out;
        HILOSel = 1'b0;
    endtask

    // Called at a negedge; returns the number of cycles Busy was high, Start cycle included.
    task automatic run_op(input logic [3:0] code, input logic [31:0] a, input logic [31:0] b,
                          input logic cancel, output int cyc);
        Start  = 1'b1;
        MDCtrl = code;
        A      = a;
        B      = b;
        Cancel = cancel;
        #1;
        cyc = 0;
        for (int i = 0; i < 40; i++) begin
            if (!Busy) break;
            cyc++;
            @(posedge clk);
            #1;
            Start  = 1'b0;
            Cancel = 1'b0;
            MDCtrl = 4'hF;
            @(negedge clk);
        end
        if (Start) begin
            @(posedge clk);
            #1;
            Start  = 1'b0;
            Cancel = 1'b0;
            MDCtrl = 4'hF;
            @(negedge clk);
        end
    endtask

    logic [31:0] hi, lo;
    int          cyc;

    initial begin
        reset   = 1'b0;
        Start   = 1'b0;
        MDCtrl  = 4'hF;
        Cancel  = 1'b0;
        A       = 32'd0;
        B       = 32'd0;
        HILOSel = 1'b0;

        repeat (2) @(negedge clk);
        read_hilo(hi, lo);
        check("reset_hi", hi, 32'h0);
        check("reset_lo", lo, 32'h0);
        check("reset_busy", {31'd0, Busy}, 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // MULT -1 * 2
        run_op(4'd0, 32'hFFFFFFFF, 32'd2, 1'b0, cyc);
        check("mult_cycles", cyc, 32'd6);
        read_hilo(hi, lo);
        check("mult_hi", hi, 32'hFFFFFFFF);
        check("mult_lo", lo, 32'hFFFFFFFE);

        // MULTU 0xFFFFFFFF * 2
        run_op(4'd2, 32'hFFFFFFFF, 32'd2, 1'b0, cyc);
        check("multu_cycles", cyc, 32'd6);
        read_hilo(hi, lo);
        check("multu_hi", hi, 32'h00000001);
        check("multu_lo", lo, 32'hFFFFFFFE);

        // DIV -7 / 2
        run_op(4'd1, 32'hFFFFFFF9, 32'd2, 1'b0, cyc);
        check("div_cycles", cyc, 32'd11);
        read_hilo(hi, lo);
        check("div_hi", hi, 32'hFFFFFFFF);
        check("div_lo", lo, 32'hFFFFFFFD);

        // MTHI / MTLO preload
        run_op(4'd4, 32'h11, 32'd0, 1'b0, cyc);
        check("mthi_cycles", cyc, 32'd0);
        run_op(4'd5, 32'h22, 32'd0, 1'b0, cyc);
        check("mtlo_cycles", cyc, 32'd0);
        read_hilo(hi, lo);
        check("mt_hi", hi, 32'h11);
        check("mt_lo", lo, 32'h22);

        // DIVU by zero keeps HI/LO
        run_op(4'd3, 32'd7, 32'd0, 1'b0, cyc);
        check("divz_cycles", cyc, 32'd11);
        read_hilo(hi, lo);
        check("divz_hi", hi, 32'h11);
        check("divz_lo", lo, 32'h22);

        // Cancelled MULT
        run_op(4'd0, 32'd3, 32'd4, 1'b1, cyc);
        check("cancel_cycles", cyc, 32'd0);
        #1 check("cancel_busy_next", {31'd0, Busy}, 32'd0);
        read_hilo(hi, lo);
        check("cancel_hi", hi, 32'h11);
        check("cancel_lo", lo, 32'h22);

        // MULT 3*4 with an MTHI and a second MULT issued during Busy, operands changed meanwhile
        Start  = 1'b1;
        MDCtrl = 4'd0;
        A      = 32'd3;
        B      = 32'd4;
        #1 check("busy_start_cycle", {31'd0, Busy}, 32'd1);
        @(posedge clk);
        #1;
        MDCtrl = 4'd4;
        A      = 32'd5;
        B      = 32'd9;
        @(negedge clk);
        #1 check("busy_during_mthi", {31'd0, Busy}, 32'd1);
        @(posedge clk);
        #1;
        MDCtrl = 4'd0;
        A      = 32'd100;
        B      = 32'd100;
        @(negedge clk);
        read_hilo(hi, lo);
        check("mthi_ignored_hi", hi, 32'h11);
        check("old_lo_while_busy", lo, 32'h22);
        @(posedge clk);
        #1;
        Start  = 1'b0;
        MDCtrl = 4'hF;
        @(negedge clk);
        cyc = 0;
        for (int i = 0; i < 40; i++) begin
            if (!Busy) break;
            cyc++;
            @(posedge clk);
            @(negedge clk);
        end
        check("mult_tail_cycles", cyc, 32'd3);
        read_hilo(hi, lo);
        check("mult34_hi", hi, 32'h0);
        check("mult34_lo", lo, 32'd12);

        // Signed corners
        run_op(4'd1, 32'h80000000, 32'hFFFFFFFF, 1'b0, cyc);
        check("ovf_cycles", cyc, 32'd11);
        read_hilo(hi, lo);
        check("ovf_hi", hi, 32'h0);
        check("ovf_lo", lo, 32'h80000000);

        run_op(4'd0, 32'hFFFFFFFD, 32'hFFFFFFFB, 1'b0, cyc);
        read_hilo(hi, lo);
        check("mult_negneg_hi", hi, 32'h0);
        check("mult_negneg_lo", lo, 32'd15);

        run_op(4'd1, 32'd7, 32'hFFFFFFFE, 1'b0, cyc);
        read_hilo(hi, lo);
        check("div_posneg_hi", hi, 32'd1);
        check("div_posneg_lo", lo, 32'hFFFFFFFD);

        // Async reset three cycles into DIVU 100/7
        Start  = 1'b1;
        MDCtrl = 4'd3;
        A      = 32'd100;
        B      = 32'd7;
        @(posedge clk);
        #1;
        Start  = 1'b0;
        MDCtrl = 4'hF;
        @(posedge clk);
        @(posedge clk);
        #2 reset = 1'b0;
        #1 check("rst_busy", {31'd0, Busy}, 32'd0);
        read_hilo(hi, lo);
        check("rst_hi", hi, 32'h0);
        check("rst_lo", lo, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        run_op(4'd3, 32'd100, 32'd7, 1'b0, cyc);
        check("divu_cycles", cyc, 32'd11);
        read_hilo(hi, lo);
        check("divu_hi", hi, 32'd2);
        check("divu_lo", lo, 32'd14);

        // MADDU on HI=0, LO=0xFFFFFFFF
        run_op(4'd4, 32'h0, 32'd0, 1'b0, cyc);
        run_op(4'd5, 32'hFFFFFFFF, 32'd0, 1'b0, cyc);
        run_op(4'd7, 32'd1, 32'd1, 1'b0, cyc);
        read_hilo(hi, lo);
`ifdef MDU_MADD_EN
        check("maddu_cycles", cyc, 32'd6);
        check("maddu_hi", hi, 32'd1);
        check("maddu_lo", lo, 32'd0);
`else
        check("maddu_off_cycles", cyc, 32'd0);
        check("maddu_off_hi", hi, 32'd0);
        check("maddu_off_lo", lo, 32'hFFFFFFFF);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
